ddr4_wr_ctrl: RTL and testbench
===============================

# ddr4_wr_ctrl

Write-side executor for the DDR4 request arbiter. Monitors the video-input FIFO, raises `write_req` when a full burst is buffered, and on `wr_cmd_start` streams exactly `BURST_LEN` beats from the FIFO into the MIG user interface at incrementing frame addresses. It then pulses `wr_end` so the arbiter returns to arbitration. It is the responder on the arbiter's write handshake, parallel to the read-side executor.

## Interface
- `ADDR_W`, 29: MIG `app_addr` width.
- `DATA_W`, 512: UI data width, equal to the FIFO width.
- `BURST_LEN`, 64: beats per arbitrated burst, power of two.
- `ADDR_STEP`, 8: `app_addr` increment per beat (BL8).
- `BASE_ADDR`, 0: frame buffer start address.
- `FRAME_BEATS`, 129600: beats per frame; must be a multiple of `BURST_LEN`.
- `clk` in 1: MIG `ui_clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `write_req` out 1: one-cycle request pulse to the arbiter.
- `wr_cmd_start` in 1: one-cycle grant pulse from the arbiter.
- `wr_end` out 1: one-cycle burst-complete pulse to the arbiter.
- `frame_sync` in 1: pulse; restart addressing at `BASE_ADDR`.
- `fifo_rd_cnt` in 10: FIFO occupancy, read side.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in DATA_W: first-word-fall-through data.
- `fifo_rd_en` out 1: FIFO pop.
- `app_en` out 1, `app_cmd` out 3, `app_addr` out ADDR_W, `app_rdy` in 1: MIG command channel.
- `app_wdf_wren` out 1, `app_wdf_end` out 1, `app_wdf_data` out DATA_W, `app_wdf_mask` out DATA_W/8, `app_wdf_rdy` in 1: MIG write-data channel.

## Operation
- States are one-hot: IDLE, BURST, DONE. The block resets to IDLE.
- Request:
  - In IDLE, if `req_pend`=0 and `fifo_rd_cnt >= BURST_LEN`, pulse `write_req` for one cycle and set `req_pend`.
  - `req_pend` clears on the `wr_end` cycle.
  - `write_req` is never asserted in the same cycle as `wr_end`.
- IDLE→BURST on `wr_cmd_start`. `wr_cmd_start` is ignored in BURST and DONE.
- Beat strobe is `xfer = BURST & app_rdy & app_wdf_rdy & !fifo_empty`.
- `app_en`, `app_wdf_wren`, `app_wdf_end` and `fifo_rd_en` all equal `xfer`. They are combinational; the MIG ready signals do not depend on enable.
- Fixed write-channel values:
  - `app_cmd` = `CMD_WRITE` (3'b000) at all times.
  - `app_wdf_data` = `fifo_dout`.
  - `app_wdf_mask` = 0.
- `beat_cnt` (log2 `BURST_LEN` bits) increments on `xfer`. When `xfer` occurs with `beat_cnt` = `BURST_LEN`-1, go BURST→DONE and clear `beat_cnt`.
- DONE: assert `wr_end` registered for one cycle, then go DONE→IDLE.
- Addressing:
  - `app_addr` is registered; it equals `BASE_ADDR` at reset.
  - On each `xfer` it advances by `ADDR_STEP`.
  - `frame_cnt` counts beats. After beat `FRAME_BEATS`-1, `app_addr` wraps to `BASE_ADDR` and `frame_cnt` to 0.
- `frame_sync`:
  - In IDLE, force `app_addr`=`BASE_ADDR` and `frame_cnt`=0 on the next edge.
  - In BURST or DONE, set `sync_pend`. Apply it on entry to IDLE, so a burst is never split across frames.
  - A pending wrap and `frame_sync` together yield `BASE_ADDR`.
- Reset mid-burst: all state clears immediately. No `wr_end` is issued; the arbiter is reset by the same `rst_n`.

## Timing
- Reset values:
  - All outputs 0, except `app_addr`=`BASE_ADDR`.
  - `app_cmd`=0 and `app_wdf_mask`=0 at all times.
- `write_req` goes high on the first edge where its condition holds in IDLE.
- `wr_cmd_start` at edge N puts the block in BURST after N. The first `xfer` is possible in cycle N+1.
- With ready and data always present, a burst takes `BURST_LEN` consecutive cycles.
- `wr_end` is high in the cycle after the last `xfer`; the block is in IDLE the cycle after that.
- The earliest next `write_req` is one cycle after `wr_end`.
- Stalls:
  - Deasserting either ready, or `fifo_empty`, stalls without losing a beat.
  - `app_addr` and `beat_cnt` hold during a stall.

## Structure
- Shared package `ddr4_pkg`: `CMD_WRITE`/`CMD_READ` constants and state encodings, shared with the read-side executor and the arbiter.
- Single module, no sub-modules. The address/frame counter may be a local always-block.

## Test plan
- Reset, then fill FIFO to 64 → `write_req` pulses once. Then `wr_cmd_start` → 64 back-to-back `xfer`, addresses 0,8,…,504; `wr_end` one cycle after beat 63.
- Toggle `app_rdy` 1/0 every cycle during a burst → 64 beats total, no duplicate or skipped address, `wr_end` count 1.
- Run 2025 bursts → the last beat lands at address 1036792, and the next burst starts at 0.
- `frame_sync` at beat 10 of a burst → the burst completes at address+8 continuity; the following burst starts at `BASE_ADDR`.
- `wr_cmd_start` while in BURST → ignored; FIFO count stays ≥64 after a burst → new `write_req` one cycle after `wr_end`, never coincident with it.
- `rst_n` low at beat 30 → all outputs go to reset values asynchronously; after release, a new burst starts at 0.

Source files
------------

// File: rtl/ddr4_pkg.sv
// Shared definitions for the DDR4 arbiter and its read/write executors.
//   CMD_WRITE / CMD_READ : MIG app_cmd encodings
//   exec_state_t         : one-hot executor state encoding (IDLE, BURST, DONE)
package ddr4_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_BURST = 3'b010,
    ST_DONE  = 3'b100
  } exec_state_t;

endpackage

// File: rtl/ddr4_wr_ctrl.sv
// Write-side executor for the DDR4 request arbiter.
// Watches the video-input FIFO, requests a slot once a full burst is buffered,
// and on grant streams BURST_LEN beats from the FIFO into the MIG user
// interface at incrementing frame-buffer addresses, then signals completion.
//
// Ports
//   clk, rst_n        : MIG ui_clk, asynchronous active-low reset
//   write_req         : one-cycle request pulse to the arbiter
//   wr_cmd_start      : one-cycle grant pulse from the arbiter
//   wr_end            : one-cycle burst-complete pulse to the arbiter
//   frame_sync        : restart addressing at BASE_ADDR (deferred to burst end)
//   fifo_rd_cnt/empty : FIFO read-side occupancy and empty flag
//   fifo_dout         : first-word-fall-through FIFO data
//   fifo_rd_en        : FIFO pop
//   app_*             : MIG command and write-data channels
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for grant; may raise write_req
// BURST | moving beats FIFO -> MIG, one per xfer
// DONE  | wr_end high for this cycle, back to IDLE next edge
module ddr4_wr_ctrl
  import ddr4_pkg::*;
#(
  parameter int ADDR_W      = 29,
  parameter int DATA_W      = 512,
  parameter int BURST_LEN   = 64,
  parameter int ADDR_STEP   = 8,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_BEATS = 129600
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  write_req,
  input  logic                  wr_cmd_start,
  output logic                  wr_end,
  input  logic                  frame_sync,
  input  logic [9:0]            fifo_rd_cnt,
  input  logic                  fifo_empty,
  input  logic [DATA_W-1:0]     fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_W-1:0]     app_addr,
  input  logic                  app_rdy,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_W-1:0]     app_wdf_data,
  output logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_rdy
);

  localparam int BEAT_W  = $clog2(BURST_LEN);
  localparam int FRAME_W = $clog2(FRAME_BEATS);

  localparam logic [9:0]         REQ_LEVEL       = 10'(BURST_LEN);
  localparam logic [BEAT_W-1:0]  LAST_BEAT       = BEAT_W'(BURST_LEN - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME_BEAT = FRAME_W'(FRAME_BEATS - 1);
  localparam logic [ADDR_W-1:0]  BASE            = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  STEP            = ADDR_W'(ADDR_STEP);

  exec_state_t          state;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [FRAME_W-1:0]   frame_cnt;
  logic                 req_pend;
  logic                 sync_pend;
  logic                 xfer;
  logic                 burst_ok;
  logic                 restart;

  assign burst_ok = (fifo_rd_cnt >= REQ_LEVEL);
  assign xfer     = (state == ST_BURST) & app_rdy & app_wdf_rdy & ~fifo_empty;

  assign app_en       = xfer;
  assign app_wdf_wren = xfer;
  assign app_wdf_end  = xfer;
  assign fifo_rd_en   = xfer;
  assign app_cmd      = CMD_WRITE;
  assign app_wdf_data = fifo_dout;
  assign app_wdf_mask = '0;

  // A frame_sync seen during a burst is held until the DONE->IDLE edge so a
  // burst never straddles two frames.
  assign restart = ((state == ST_IDLE) & frame_sync) |
                   ((state == ST_DONE) & (sync_pend | frame_sync));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      req_pend  <= 1'b0;
      sync_pend <= 1'b0;
      write_req <= 1'b0;
      wr_end    <= 1'b0;
    end else begin
      write_req <= 1'b0;
      wr_end    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!req_pend && burst_ok) begin
            write_req <= 1'b1;
            req_pend  <= 1'b1;
          end
          if (wr_cmd_start) state <= ST_BURST;
        end
        ST_BURST: begin
          if (frame_sync) sync_pend <= 1'b1;
          if (xfer) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              wr_end   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        ST_DONE: begin
          // wr_end is high now, so the old request is retired on this edge;
          // a fresh one is raised on the same edge so it lands right after wr_end.
          req_pend  <= burst_ok;
          write_req <= burst_ok;
          sync_pend <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_addr  <= BASE;
      frame_cnt <= '0;
    end else if (restart) begin
      app_addr  <= BASE;
      frame_cnt <= '0;
    end else if (xfer) begin
      if (frame_cnt == LAST_FRAME_BEAT) begin
        app_addr  <= BASE;
        frame_cnt <= '0;
      end else begin
        app_addr  <= app_addr + STEP;
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddr4_wr_ctrl.sv
// Self-checking bench for ddr4_wr_ctrl. A behavioural FIFO and a small state
// model drive a scoreboard of expected {addr, data} beats, pushed on grant and
// popped on every app_en. The frame is shortened to 3 bursts so the address
// wrap is reached quickly (last beat of a frame at 191*8 = 1528).
module tb_ddr4_wr_ctrl;
  import ddr4_pkg::*;

  localparam int ADDR_W      = 29;
  localparam int DATA_W      = 32;
  localparam int BURST_LEN   = 64;
  localparam int ADDR_STEP   = 8;
  localparam int BASE_ADDR   = 0;
  localparam int FRAME_BEATS = 192;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                write_req, wr_cmd_start, wr_end, frame_sync;
  logic [9:0]          fifo_rd_cnt;
  logic                fifo_empty, fifo_rd_en;
  logic [DATA_W-1:0]   fifo_dout;
  logic                app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [2:0]          app_cmd;
  logic [ADDR_W-1:0]   app_addr;
  logic [DATA_W-1:0]   app_wdf_data;
  logic [DATA_W/8-1:0] app_wdf_mask;

  always #5 clk = ~clk;

  ddr4_wr_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .ADDR_STEP(ADDR_STEP), .BASE_ADDR(BASE_ADDR), .FRAME_BEATS(FRAME_BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .write_req(write_req), .wr_cmd_start(wr_cmd_start),
    .wr_end(wr_end), .frame_sync(frame_sync), .fifo_rd_cnt(fifo_rd_cnt),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef enum int {M_IDLE, M_BURST, M_DONE} mstate_t;

  beat_t   sb_q[$];
  int      n_cmp = 0, n_err = 0;
  int      cyc = 0;

  mstate_t           mstate;
  int                mbeats, m_frame, m_widx;
  logic [ADDR_W-1:0] m_addr;
  bit                m_sync, m_pend, exp_wreq;

  int  fifo_level, rd_idx;
  bit  start_nxt, sync_nxt, force_empty, end_seen;
  int  rdy_mode, sync_at, dup_at;
  int  n_wreq, n_wend, start_cyc, first_beat_cyc, last_beat_cyc, wreq_cyc, wend_cyc;
  logic [ADDR_W-1:0] first_addr, last_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] word(input int i);
    return DATA_W'(32'h5A00_0000 ^ i);
  endfunction

  task automatic push_burst();
    for (int i = 0; i < BURST_LEN; i++) begin
      sb_q.push_back('{addr: m_addr, data: word(m_widx)});
      m_widx++;
      if (m_frame == FRAME_BEATS - 1) begin
        m_addr  = BASE;
        m_frame = 0;
      end else begin
        m_addr  = m_addr + ADDR_W'(ADDR_STEP);
        m_frame++;
      end
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    mstate = M_IDLE; mbeats = 0; m_frame = 0; m_addr = BASE;
    m_sync = 0; m_pend = 0; exp_wreq = 0; m_widx = rd_idx;
  endtask

  task automatic monitor();
    bit    exp_xfer, cnt_ok, nreq;
    beat_t b;
    exp_xfer = (mstate == M_BURST) && app_rdy && app_wdf_rdy && !fifo_empty;
    chk("cmd_mask", 64'({app_cmd, app_wdf_mask}), 64'(0));
    chk("strobes", 64'({app_en, app_wdf_wren, app_wdf_end, fifo_rd_en}), exp_xfer ? 64'hF : 64'h0);
    chk("write_req", 64'(write_req), 64'(exp_wreq));
    chk("wr_end", 64'(wr_end), 64'(mstate == M_DONE));
    chk("req_end_overlap", 64'(write_req & wr_end), 64'(0));
    if (write_req) begin n_wreq++; wreq_cyc = cyc; end
    if (wr_end) begin
      n_wend++; wend_cyc = cyc; end_seen = 1;
      chk("wr_end_lat", 64'(cyc - last_beat_cyc), 64'(1));
    end
    if (app_en) begin
      if (sb_q.size() == 0) chk("extra_beat", 64'(1), 64'(0));
      else begin
        b = sb_q.pop_front();
        chk("addr", 64'(app_addr), 64'(b.addr));
        chk("data", 64'(app_wdf_data), 64'(b.data));
      end
      if (mbeats == 0) begin first_beat_cyc = cyc; first_addr = app_addr; end
      last_beat_cyc = cyc; last_addr = app_addr;
      if (fifo_level > 0) fifo_level--;
      rd_idx++;
    end
    cnt_ok = (fifo_rd_cnt >= 10'(BURST_LEN));
    nreq = 0;
    if (mstate == M_IDLE && !m_pend && cnt_ok) begin nreq = 1; m_pend = 1; end
    else if (mstate == M_DONE) begin nreq = cnt_ok; m_pend = cnt_ok; end
    exp_wreq = nreq;
    case (mstate)
      M_IDLE: begin
        if (frame_sync) begin m_addr = BASE; m_frame = 0; end
        if (wr_cmd_start) begin
          push_burst(); mstate = M_BURST; mbeats = 0; start_cyc = cyc;
        end
      end
      M_BURST: begin
        if (frame_sync) m_sync = 1;
        if (exp_xfer) begin
          mbeats++;
          if (mbeats == sync_at) sync_nxt = 1;
          if (mbeats == dup_at) start_nxt = 1;
          if (mbeats == BURST_LEN) mstate = M_DONE;
        end
      end
      default: begin
        if (frame_sync) m_sync = 1;
        if (m_sync) begin m_addr = BASE; m_frame = 0; m_sync = 0; end
        mstate = M_IDLE;
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    wr_cmd_start = start_nxt; start_nxt = 0;
    frame_sync   = sync_nxt;  sync_nxt  = 0;
    if (rdy_mode == 0) begin
      app_rdy = 1'b1; app_wdf_rdy = 1'b1; force_empty = 0;
    end else begin
      app_rdy     = cyc[0];
      app_wdf_rdy = ($urandom_range(3, 0) != 0);
      force_empty = ($urandom_range(4, 0) == 0);
    end
    fifo_rd_cnt = (fifo_level > 1023) ? 10'd1023 : 10'(fifo_level);
    fifo_empty  = (fifo_level == 0) || force_empty;
    fifo_dout   = word(rd_idx);
    #1;
    monitor();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 64'({write_req, wr_end, app_en, app_wdf_wren, app_wdf_end, fifo_rd_en}), 64'(0));
    chk("async_rst_addr", 64'(app_addr), 64'(BASE));
    model_reset();
    wr_cmd_start = 0; frame_sync = 0; fifo_rd_cnt = '0; fifo_empty = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_burst(input int s_at, input int d_at, input int r_at);
    int  n;
    bit  aborted;
    sync_at = s_at; dup_at = d_at; end_seen = 0; aborted = 0; start_nxt = 1; n = 0;
    while (!end_seen && !aborted && n < 1000) begin
      step();
      n++;
      if (r_at > 0 && mstate == M_BURST && mbeats == r_at) begin
        mid_reset();
        aborted = 1;
      end
    end
    if (!end_seen && !aborted) chk("burst_timeout", 64'(0), 64'(1));
    sync_at = 0; dup_at = 0;
  endtask

  task automatic wait_req();
    int n0, k;
    n0 = n_wreq; k = 0;
    while (n_wreq == n0 && k < 50) begin step(); k++; end
    if (n_wreq == n0) chk("req_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wend0;
    rst_n = 1'b0; wr_cmd_start = 0; frame_sync = 0; fifo_rd_cnt = '0; fifo_empty = 1'b1;
    fifo_dout = '0; app_rdy = 0; app_wdf_rdy = 0;
    fifo_level = 0; rd_idx = 0; rdy_mode = 0; start_nxt = 0; sync_nxt = 0; force_empty = 0;
    sync_at = 0; dup_at = 0; n_wreq = 0; n_wend = 0; end_seen = 0;
    start_cyc = 0; first_beat_cyc = 0; last_beat_cyc = 0; wreq_cyc = 0; wend_cyc = 0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", 64'({write_req, wr_end, app_en, app_wdf_wren, app_wdf_end, fifo_rd_en}), 64'(0));
    chk("rst_addr", 64'(app_addr), 64'(BASE));
    chk("rst_cmd_mask", 64'({app_cmd, app_wdf_mask}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Burst 1: full FIFO, always ready -> addresses 0..504 back to back.
    fifo_level = 64;
    repeat (8) step();
    chk("req_once", 64'(n_wreq), 64'(1));
    run_burst(0, 0, 0);
    chk("first_beat_lat", 64'(first_beat_cyc - start_cyc), 64'(1));
    chk("burst_cycles", 64'(last_beat_cyc - first_beat_cyc), 64'(BURST_LEN - 1));
    chk("b1_last_addr", 64'(last_addr), 64'(BASE + 63 * ADDR_STEP));
    chk("b1_sb_empty", 64'(sb_q.size()), 64'(0));

    // Burst 2: stalls on both readies and empty, stray grant at beat 5,
    // 64 words left afterwards so the next request follows wr_end directly.
    fifo_level = 128;
    wait_req();
    rdy_mode = 1;
    wend0 = n_wend;
    run_burst(0, 5, 0);
    rdy_mode = 0;
    chk("b2_wend_once", 64'(n_wend - wend0), 64'(1));
    chk("b2_sb_empty", 64'(sb_q.size()), 64'(0));
    step();
    chk("req_after_end", 64'(wreq_cyc - wend_cyc), 64'(1));

    // Burst 3 closes the shortened frame; address wraps to base.
    run_burst(0, 0, 0);
    chk("frame_last_addr", 64'(last_addr), 64'(BASE + (FRAME_BEATS - 1) * ADDR_STEP));
    step();
    chk("wrap_addr", 64'(app_addr), 64'(BASE));

    // Burst 4: frame_sync at beat 10 must not split the burst.
    fifo_level = 64;
    wait_req();
    run_burst(10, 0, 0);
    chk("sync_burst_last", 64'(last_addr), 64'(BASE + 63 * ADDR_STEP));
    step();
    chk("sync_idle_addr", 64'(app_addr), 64'(BASE));

    // Burst 5 starts at base again, reset lands at beat 30.
    fifo_level = 64;
    wait_req();
    run_burst(0, 0, 30);
    chk("after_sync_start", 64'(first_addr), 64'(BASE));

    // Burst 6 after reset restarts at base.
    fifo_level = fifo_level + 64;
    wait_req();
    run_burst(0, 0, 0);
    chk("after_rst_start", 64'(first_addr), 64'(BASE));
    chk("b6_sb_empty", 64'(sb_q.size()), 64'(0));
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
